megaram_mem_arbiter: RTL and testbench
======================================

# megaram_mem_arbiter

Arbitrates the single external memory port between two requesters: the MegaRAM cartridge path, which carries Z80 slot accesses already translated to 23-bit memory addresses, and the image loader, which writes and reads back ROM images from the host side. It sits between the cartridge mapper and the memory controller. It stretches the Z80 cycle with WAIT until cartridge data is ready, and it guarantees the loader a bounded service latency. A watchdog aborts any memory transaction that is never acknowledged.

## Interface
- TIMEOUT, 64: cycles in a busy state without mem_ack before the access is aborted.
- LD_MAX_WAIT, 16: cycles ld_req may wait unserved before the loader outranks the cartridge.
- clk  in  1  system clock; the single clock domain.
- reset_n  in  1  asynchronous active-low reset.
- cart_rd  in  1  cartridge read strobe, level, already qualified by cartridge enable.
- cart_wr  in  1  cartridge write strobe, level; if cart_rd is also high, the access is a write.
- cart_addr  in  23  translated memory address.
- cart_din  in  8  write data from the Z80.
- cart_dout  out  8  last cartridge read data, held between reads.
- cart_wait_n  out  1  Z80 WAIT, active low.
- ld_req  in  1  loader request, level.
- ld_we  in  1  loader write select.
- ld_addr  in  23  loader address.
- ld_din  in  8  loader write data.
- ld_dout  out  8  loader read data, valid while ld_ack is high.
- ld_ack  out  1  one-cycle completion pulse to the loader.
- mem_req  out  1  memory request, level.
- mem_we  out  1  memory write select.
- mem_addr  out  23  memory address.
- mem_wdata  out  8  memory write data.
- mem_rdata  in  8  memory read data, valid while mem_ack is high.
- mem_ack  in  1  one-cycle completion pulse from the memory controller.
- timeout_err  out  1  sticky flag: an access was aborted.

## Operation
- FSM states: IDLE, CART_BUSY, LD_BUSY.
- cart_act = cart_rd | cart_wr.
- cart_done register:
  - set when a cartridge access completes;
  - cleared in any cycle where cart_act = 0.
  - One memory access is issued per strobe assertion.
- cart_pend = cart_act & ~cart_done.
- cart_wait_n = ~cart_pend. This output is combinational from the strobes so WAIT is asserted within the same cycle as the strobe.
- ld_wait_cnt:
  - counts cycles where ld_req = 1 and ld_ack = 0;
  - saturates at LD_MAX_WAIT;
  - clears on ld_ack or when ld_req = 0.
- IDLE priority:
  - cart_pend and ld_req both high: the loader is served if ld_wait_cnt >= LD_MAX_WAIT, otherwise the cartridge.
  - Only one of them high: that requester is served.
  - Neither high: stay in IDLE.
- Issue: register mem_req = 1 together with mem_we/mem_addr/mem_wdata from the selected requester, then enter the matching BUSY state. These outputs stay stable until the state leaves BUSY.
- CART_BUSY on mem_ack:
  - on a read, cart_dout <= mem_rdata;
  - set cart_done, mem_req <= 0, go to IDLE.
- LD_BUSY on mem_ack: ld_dout <= mem_rdata; ld_ack <= 1 for one cycle; mem_req <= 0; go to IDLE.
- Watchdog: a counter runs in the BUSY states. When it reaches TIMEOUT - 1 without mem_ack, the access completes as if acked with data 8'hFF and timeout_err is set. timeout_err is cleared only by reset.
- mem_ack received while in IDLE is ignored.
- If cart_act falls during CART_BUSY (aborted Z80 cycle), the memory access still completes. cart_done is then not set, so the next strobe issues a fresh access.
- ld_req held high after ld_ack is treated as a new request and re-arbitrated in IDLE.

## Timing
- Reset values:
  - mem_req, mem_we, ld_ack, timeout_err = 0;
  - mem_addr = 0, mem_wdata = 0, ld_dout = 8'h00, cart_dout = 8'hFF;
  - state = IDLE, counters = 0;
  - cart_wait_n is forced 1 while reset_n = 0.
- Reset mid-transaction drops mem_req immediately. The memory controller tolerates this.
- Latency: a request seen in IDLE at cycle 0 gives mem_req = 1 at cycle 1. mem_ack at cycle k gives mem_req = 0, ld_ack or cart_done, and updated data at cycle k+1. cart_wait_n rises at k+1. The earliest next issue is at cycle k+2.
- Minimum cartridge read: mem_ack at cycle 1 means WAIT is asserted for 2 cycles.
- Timeout: with mem_req = 1 at cycle 1 and no ack, completion happens at cycle TIMEOUT+1.

## Test plan
- Cartridge read at 23'h420123, memory acks after 3 cycles with 8'h5A: cart_wait_n is low from the strobe cycle until ack+1, then cart_dout = 8'h5A. A single mem_req is issued even with the strobe held 20 cycles.
- Loader write (23'h000010, 8'hC3): mem_we = 1, mem_wdata = 8'hC3, one ld_ack pulse. Back-to-back ld_req gives issues 2 cycles after each ack.
- Cartridge and loader request in the same cycle: cartridge served first. With cartridge strobes repeated every 4 cycles and ld_req held, the loader is issued once ld_wait_cnt reaches 16.
- No mem_ack on a cartridge read: at issue+64 cart_dout = 8'hFF, cart_wait_n = 1, timeout_err = 1 and stays 1. A late mem_ack is ignored.
- reset_n pulsed low during LD_BUSY: mem_req = 0 and ld_ack = 0 asynchronously, all reset values restored, and normal operation resumes after release.
- Strobe dropped during CART_BUSY: the access completes, and the next strobe triggers a new mem_req.

Source files
------------

// File: rtl/megaram_mem_arbiter.sv
// Shares the external memory port between the MegaRAM cartridge path and the image loader.
// Cartridge cycles are stretched with WAIT; the loader gets priority after a bounded wait.
module megaram_mem_arbiter #(
    parameter int TIMEOUT     = 64,
    parameter int LD_MAX_WAIT = 16
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        cart_rd,
    input  logic        cart_wr,
    input  logic [22:0] cart_addr,
    input  logic [7:0]  cart_din,
    output logic [7:0]  cart_dout,
    output logic        cart_wait_n,
    input  logic        ld_req,
    input  logic        ld_we,
    input  logic [22:0] ld_addr,
    input  logic [7:0]  ld_din,
    output logic [7:0]  ld_dout,
    output logic        ld_ack,
    output logic        mem_req,
    output logic        mem_we,
    output logic [22:0] mem_addr,
    output logic [7:0]  mem_wdata,
    input  logic [7:0]  mem_rdata,
    input  logic        mem_ack,
    output logic        timeout_err
);
    localparam int WD_W = $clog2(TIMEOUT);
    localparam int LW_W = $clog2(LD_MAX_WAIT + 1);

    typedef enum logic [1:0] {IDLE, CART_BUSY, LD_BUSY} state_t;

    state_t          state;
    logic            cart_done;
    logic [WD_W-1:0] wd_cnt;
    logic [LW_W-1:0] ld_wait_cnt;

    logic       cart_act, cart_pend, wd_expire, busy_done, ld_first;
    logic [7:0] rdata_eff;

    assign cart_act  = cart_rd | cart_wr;
    assign cart_pend = cart_act & ~cart_done;
    // WAIT must drop in the strobe cycle itself, so it is decoded straight from the strobes.
    assign cart_wait_n = ~reset_n | ~cart_pend;

    assign wd_expire = (state != IDLE) && !mem_ack && (wd_cnt == WD_W'(TIMEOUT - 1));
    assign busy_done = (state != IDLE) && (mem_ack || wd_expire);
    assign rdata_eff = mem_ack ? mem_rdata : 8'hFF;
    assign ld_first  = ld_req && (!cart_pend || ld_wait_cnt >= LW_W'(LD_MAX_WAIT));

    // An aborted Z80 cycle (strobe gone at completion) leaves cart_done clear, so the next strobe re-issues.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            cart_done <= 1'b0;
        else if (!cart_act)
            cart_done <= 1'b0;
        else if (state == CART_BUSY && busy_done)
            cart_done <= 1'b1;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n)
            ld_wait_cnt <= '0;
        else if (!ld_req || ld_ack)
            ld_wait_cnt <= '0;
        else if (ld_wait_cnt < LW_W'(LD_MAX_WAIT))
            ld_wait_cnt <= ld_wait_cnt + LW_W'(1);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state       <= IDLE;
            mem_req     <= 1'b0;
            mem_we      <= 1'b0;
            mem_addr    <= '0;
            mem_wdata   <= '0;
            ld_ack      <= 1'b0;
            ld_dout     <= 8'h00;
            cart_dout   <= 8'hFF;
            timeout_err <= 1'b0;
            wd_cnt      <= '0;
        end else begin
            ld_ack <= 1'b0;
            case (state)
                IDLE: begin
                    wd_cnt <= '0;
                    if (ld_first) begin
                        mem_req   <= 1'b1;
                        mem_we    <= ld_we;
                        mem_addr  <= ld_addr;
                        mem_wdata <= ld_din;
                        state     <= LD_BUSY;
                    end else if (cart_pend) begin
                        mem_req   <= 1'b1;
                        mem_we    <= cart_wr;
                        mem_addr  <= cart_addr;
                        mem_wdata <= cart_din;
                        state     <= CART_BUSY;
                    end
                end
                CART_BUSY, LD_BUSY: begin
                    if (busy_done) begin
                        mem_req <= 1'b0;
                        state   <= IDLE;
                        if (state == CART_BUSY) begin
                            if (!mem_we)
                                cart_dout <= rdata_eff;
                        end else begin
                            ld_dout <= rdata_eff;
                            ld_ack  <= 1'b1;
                        end
                        if (wd_expire)
                            timeout_err <= 1'b1;
                    end else begin
                        wd_cnt <= wd_cnt + WD_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_megaram_mem_arbiter.sv
// Randomised and directed bench: a memory-controller model answers requests, a scoreboard
// holds expected issues and completions, and a monitor checks them as the DUT produces them.
module tb_megaram_mem_arbiter;
    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        cart_rd, cart_wr, ld_req, ld_we, mem_ack;
    logic [22:0] cart_addr, ld_addr;
    logic [7:0]  cart_din, ld_din, mem_rdata;
    logic [7:0]  cart_dout, ld_dout, mem_wdata;
    logic        cart_wait_n, ld_ack, mem_req, mem_we, timeout_err;
    logic [22:0] mem_addr;

    always #5 clk = ~clk;

    megaram_mem_arbiter dut (
        .clk(clk), .reset_n(reset_n),
        .cart_rd(cart_rd), .cart_wr(cart_wr), .cart_addr(cart_addr), .cart_din(cart_din),
        .cart_dout(cart_dout), .cart_wait_n(cart_wait_n),
        .ld_req(ld_req), .ld_we(ld_we), .ld_addr(ld_addr), .ld_din(ld_din),
        .ld_dout(ld_dout), .ld_ack(ld_ack),
        .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata), .mem_ack(mem_ack), .timeout_err(timeout_err)
    );

    typedef struct { logic we; logic [22:0] addr; logic [7:0] wd; } iss_t;
    typedef struct { logic rd; logic [7:0] data; } rsp_t;

    iss_t       iss_q[$];
    rsp_t       cart_q[$];
    rsp_t       ld_q[$];
    logic [7:0] mem_arr[int];
    logic [7:0] ref_mem[int];
    int         total = 0;
    int         bad = 0;
    int         cyc = 0;
    int         ack_dly = 0;
    bit         ack_en = 1'b1;
    int         stray_at = -1;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [7:0] def_data(input logic [22:0] a);
        return a[7:0] ^ a[15:8] ^ 8'hA5;
    endfunction

    function automatic logic [7:0] ref_rd(input logic [22:0] a);
        return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : def_data(a);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, exp);
        end
    endtask

    task automatic push_iss(input logic we, input logic [22:0] a, input logic [7:0] wd);
        iss_t e;
        e.we = we; e.addr = a; e.wd = wd;
        iss_q.push_back(e);
    endtask

    task automatic push_rsp(input bit is_cart, input logic rd, input logic [7:0] d);
        rsp_t r;
        r.rd = rd; r.data = d;
        if (is_cart) cart_q.push_back(r);
        else ld_q.push_back(r);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Memory controller model: acks ack_dly cycles after mem_req is first seen.
    initial begin
        int n;
        n = 0;
        mem_ack = 1'b0;
        mem_rdata = 8'h00;
        forever begin
            @(posedge clk);
            #1;
            if (!reset_n) begin
                mem_ack = 1'b0; n = 0;
            end else if (mem_ack) begin
                mem_ack = 1'b0; n = 0;
            end else if (cyc == stray_at) begin
                mem_ack = 1'b1; mem_rdata = 8'h77;
            end else if (mem_req && ack_en) begin
                if (n >= ack_dly) begin
                    mem_ack = 1'b1;
                    if (mem_we) begin
                        mem_arr[int'(mem_addr)] = mem_wdata;
                        mem_rdata = 8'h00;
                    end else begin
                        mem_rdata = mem_arr.exists(int'(mem_addr)) ? mem_arr[int'(mem_addr)] : def_data(mem_addr);
                    end
                end else begin
                    n++;
                end
            end else if (!mem_req) begin
                n = 0;
            end
        end
    end

    // Monitor: issues, loader completions and cartridge completions against the scoreboard.
    initial begin
        logic pr, pw;
        iss_t e;
        rsp_t r;
        pr = 1'b0;
        pw = 1'b1;
        forever begin
            @(negedge clk);
            if (reset_n) begin
                if (mem_req && !pr) begin
                    if (iss_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL issue_unexpected: got addr %0h want no issue", mem_addr);
                    end else begin
                        e = iss_q.pop_front();
                        chk("issue_we", 32'(mem_we), 32'(e.we));
                        chk("issue_addr", 32'(mem_addr), 32'(e.addr));
                        chk("issue_wdata", 32'(mem_wdata), 32'(e.wd));
                    end
                end
                if (ld_ack) begin
                    if (ld_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL ld_ack_unexpected: got ld_ack=1 want 0");
                    end else begin
                        r = ld_q.pop_front();
                        if (r.rd) chk("ld_dout", 32'(ld_dout), 32'(r.data));
                    end
                end
                if (cart_wait_n && !pw && (cart_rd || cart_wr)) begin
                    if (cart_q.size() == 0) begin
                        total++; bad++;
                        $display("FAIL cart_done_unexpected: got wait release want none");
                    end else begin
                        r = cart_q.pop_front();
                        if (r.rd) chk("cart_dout", 32'(cart_dout), 32'(r.data));
                    end
                end
            end
            pr = mem_req;
            pw = cart_wait_n;
        end
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got no finish want finish");
        $fatal(1, "bench timeout");
    end

    initial begin
        int low, iss_n, n, acks, ai, ii, ld_iss;
        int ackc[3];
        int issc[3];
        logic pr, we, got;
        logic [22:0] a;
        logic [7:0] d, exp;

        cart_rd = 1'b1; cart_wr = 1'b0; cart_addr = '0; cart_din = '0;
        ld_req = 1'b0; ld_we = 1'b0; ld_addr = '0; ld_din = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_req", 32'(mem_req), 0);
        chk("rst_mem_we", 32'(mem_we), 0);
        chk("rst_ld_ack", 32'(ld_ack), 0);
        chk("rst_timeout_err", 32'(timeout_err), 0);
        chk("rst_mem_addr", 32'(mem_addr), 0);
        chk("rst_mem_wdata", 32'(mem_wdata), 0);
        chk("rst_ld_dout", 32'(ld_dout), 0);
        chk("rst_cart_dout", 32'(cart_dout), 32'hFF);
        chk("rst_wait_forced", 32'(cart_wait_n), 1);
        step();
        cart_rd = 1'b0;
        reset_n = 1'b1;
        step(); step();

        // Cartridge read, ack 3 cycles after issue, strobe held for 20 cycles.
        mem_arr[int'(23'h420123)] = 8'h5A;
        ref_mem[int'(23'h420123)] = 8'h5A;
        ack_dly = 3;
        cart_addr = 23'h420123; cart_din = 8'h00; cart_rd = 1'b1;
        push_iss(1'b0, 23'h420123, 8'h00);
        push_rsp(1'b1, 1'b1, ref_rd(23'h420123));
        low = 0; iss_n = 0; pr = 1'b0;
        repeat (20) begin
            @(negedge clk);
            if (!cart_wait_n) low++;
            if (mem_req && !pr) iss_n++;
            pr = mem_req;
            step();
        end
        chk("cart_rd_wait_cycles", low, 5);
        chk("cart_rd_single_issue", iss_n, 1);
        chk("cart_rd_data", 32'(cart_dout), 32'h5A);
        cart_rd = 1'b0;
        step();

        // Loader write held for three back-to-back accesses.
        ack_dly = 1;
        ld_we = 1'b1; ld_addr = 23'h000010; ld_din = 8'hC3; ld_req = 1'b1;
        ref_mem[int'(23'h000010)] = 8'hC3;
        repeat (3) begin
            push_iss(1'b1, 23'h000010, 8'hC3);
            push_rsp(1'b0, 1'b0, 8'h00);
        end
        acks = 0; ai = 0; ii = 0; pr = 1'b0; n = 0;
        while (acks < 3 && n < 60) begin
            @(negedge clk);
            if (mem_ack && ai < 3) begin ackc[ai] = n; ai++; end
            if (mem_req && !pr && ii < 3) begin issc[ii] = n; ii++; end
            pr = mem_req;
            if (ld_ack) acks++;
            if (acks == 3) ld_req = 1'b0;
            n++;
        end
        ld_req = 1'b0;
        chk("ld_b2b_acks", acks, 3);
        chk("ld_b2b_gap1", issc[1] - ackc[0], 2);
        chk("ld_b2b_gap2", issc[2] - ackc[1], 2);
        step(); step();

        // Simultaneous requests; cartridge re-strobes every 4 cycles until the loader outranks it.
        ack_dly = 2;
        cart_addr = 23'h000200; cart_din = 8'h11;
        ld_we = 1'b1; ld_addr = 23'h000300; ld_din = 8'h22;
        ref_mem[int'(23'h000300)] = 8'h22;
        repeat (4) push_iss(1'b0, 23'h000200, 8'h11);
        push_iss(1'b1, 23'h000300, 8'h22);
        push_rsp(1'b0, 1'b0, 8'h00);
        ld_iss = -1; pr = 1'b0;
        for (int c = 0; c < 30; c++) begin
            cart_rd = (c < 19) && (c % 4 != 3);
            if (c == 0) ld_req = 1'b1;
            @(negedge clk);
            if (mem_req && !pr && mem_we) ld_iss = c;
            pr = mem_req;
            if (ld_ack) ld_req = 1'b0;
            step();
        end
        ld_req = 1'b0; cart_rd = 1'b0;
        chk("ld_priority_issue_cycle", ld_iss, 17);
        step();

        // Unacknowledged cartridge read hits the watchdog.
        ack_en = 1'b0;
        cart_addr = 23'h0ABCDE; cart_din = 8'h00; cart_rd = 1'b1;
        push_iss(1'b0, 23'h0ABCDE, 8'h00);
        push_rsp(1'b1, 1'b1, 8'hFF);
        low = 0;
        for (int k = 0; k < 100; k++) begin
            @(negedge clk);
            if (cart_wait_n) break;
            low++;
        end
        chk("timeout_wait_cycles", low, 65);
        chk("timeout_err_set", 32'(timeout_err), 1);
        step();
        cart_rd = 1'b0;
        stray_at = cyc + 2;
        repeat (5) step();
        chk("timeout_err_sticky", 32'(timeout_err), 1);
        chk("stray_ack_ignored", 32'(cart_dout), 32'hFF);
        ack_en = 1'b1;

        // Strobe dropped mid-access, then a fresh strobe.
        ack_dly = 3;
        cart_addr = 23'h000055; cart_din = 8'h00; cart_rd = 1'b1;
        push_iss(1'b0, 23'h000055, 8'h00);
        step(); step();
        cart_rd = 1'b0;
        for (int k = 0; k < 20; k++) begin
            @(negedge clk);
            if (!mem_req) break;
        end
        chk("abort_access_completes", 32'(mem_req), 0);
        step(); step();
        cart_rd = 1'b1;
        push_iss(1'b0, 23'h000055, 8'h00);
        push_rsp(1'b1, 1'b1, ref_rd(23'h000055));
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (cart_wait_n) break;
        end
        chk("abort_reissue_done", 32'(cart_wait_n), 1);
        step();
        cart_rd = 1'b0;
        step();

        // Loader read for a non-reset ld_dout, then reset in the middle of a loader access.
        ack_dly = 0;
        ld_we = 1'b0; ld_addr = 23'h000010; ld_din = 8'h9E; ld_req = 1'b1;
        push_iss(1'b0, 23'h000010, 8'h9E);
        push_rsp(1'b0, 1'b1, ref_rd(23'h000010));
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (ld_ack) begin ld_req = 1'b0; break; end
        end
        ld_req = 1'b0;
        step(); step();
        ack_en = 1'b0;
        ld_addr = 23'h000020; ld_din = 8'h00; ld_req = 1'b1;
        push_iss(1'b0, 23'h000020, 8'h00);
        repeat (4) step();
        @(negedge clk);
        reset_n = 1'b0;
        ld_req = 1'b0;
        #1;
        chk("rst_busy_mem_req", 32'(mem_req), 0);
        chk("rst_busy_ld_ack", 32'(ld_ack), 0);
        chk("rst_busy_timeout_err", 32'(timeout_err), 0);
        chk("rst_busy_cart_dout", 32'(cart_dout), 32'hFF);
        chk("rst_busy_ld_dout", 32'(ld_dout), 0);
        chk("rst_busy_mem_addr", 32'(mem_addr), 0);
        step();
        reset_n = 1'b1;
        ack_en = 1'b1;
        step();

        // Randomised single-requester traffic against the reference memory.
        for (int i = 0; i < 80; i++) begin
            we = 1'($urandom_range(0, 1));
            a = 23'h000100 + 23'($urandom_range(0, 7));
            d = 8'($urandom);
            ack_dly = $urandom_range(0, 4);
            exp = ref_rd(a);
            push_iss(we, a, d);
            if (we) ref_mem[int'(a)] = d;
            got = 1'b0;
            if ($urandom_range(0, 1) == 1) begin
                push_rsp(1'b1, !we, exp);
                cart_addr = a; cart_din = d; cart_wr = we;
                cart_rd = !we || ($urandom_range(0, 1) == 1);
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (cart_wait_n) begin got = 1'b1; break; end
                end
                step();
                cart_rd = 1'b0; cart_wr = 1'b0;
            end else begin
                push_rsp(1'b0, !we, exp);
                ld_addr = a; ld_din = d; ld_we = we; ld_req = 1'b1;
                for (int k = 0; k < 100; k++) begin
                    @(negedge clk);
                    if (ld_ack) begin got = 1'b1; ld_req = 1'b0; break; end
                end
                ld_req = 1'b0;
                step();
            end
            if (!got) chk("rand_op_completes", 32'(got), 1);
            repeat ($urandom_range(1, 2)) step();
        end

        repeat (5) step();
        chk("queues_drained", iss_q.size() + cart_q.size() + ld_q.size(), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
